// File: rtl/pool_pkg.sv
// Shared definitions for the pooling engine.
//   pool_mode_e : pooling operation selector (max / average)
//   fmt_out     : widens a WD-bit signed result into the 2*WD-bit ofmap
//                 format: sign-extension, the value, then FI zero fraction bits.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Only the low wd bits of r are meaningful; they are re-sign-extended here
  // so callers may pass a wider accumulator value.
  // The caller truncates the result to 2*wd bits.
  function automatic logic [63:0] fmt_out(input logic [63:0] r,
                                          input int unsigned wd,
                                          input int unsigned fi);
    logic signed [63:0] s;
    s = signed'(r << (64 - wd));
    s = s >>> (64 - wd);
    return 64'(s <<< fi);
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One pooling channel: accumulator, max-compare / add path, average shift
// and the formatted output register.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   beat_i       : an accepted window beat is present this cycle
//   first_i      : the beat is the first of its window
//   last_i       : the beat is the last of its window
//   mode_i       : pooling mode in effect for this beat
//   x_i          : signed input element
//   out_data_o   : formatted result, updated on the last beat only
module pool_lane
  import pool_pkg::*;
#(
  parameter int WD       = 8,
  parameter int FI       = 3,
  parameter int WIN_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 beat_i,
  input  logic                 first_i,
  input  logic                 last_i,
  input  pool_mode_e           mode_i,
  input  logic signed [WD-1:0] x_i,
  output logic [2*WD-1:0]      out_data_o
);

  localparam int AW = WD + WIN_LOG2;

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] comb;
  logic signed [AW-1:0] res;
  logic [2*WD-1:0]      out_q, out_d;

  always_comb begin
    x_ext = AW'(x_i);
    // The accumulator combined with the current beat; on the last beat this
    // is the full-window value, so the result needs no extra cycle.
    if (first_i) begin
      comb = x_ext;
    end else if (mode_i == POOL_AVG) begin
      comb = acc_q + x_ext;
    end else begin
      comb = (x_ext > acc_q) ? x_ext : acc_q;
    end
    // Arithmetic shift floors toward -inf; the quotient always fits in WD bits.
    res   = (mode_i == POOL_AVG) ? (comb >>> WIN_LOG2) : comb;
    acc_d = beat_i ? comb : acc_q;
    out_d = (beat_i && last_i) ? (2*WD)'(fmt_out(64'(res), WD, FI)) : out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign out_data_o = out_q;

endmodule

// File: rtl/pool_unit.sv
// Max/average pooling engine: accumulates 2**WIN_LOG2 beats per window on
// CH parallel lanes and emits one formatted result pulse per window.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : in_data carries a window beat
//   in_data    : CH signed WD-bit lanes, lane k at [k*WD +: WD]
//   pool_mode  : 0 max, 1 average; taken on the first beat of a window
//   flush      : drops the partial window and the beat in flight
//   out_valid  : one-cycle result pulse
//   out_data   : CH 2*WD-bit lanes, lane k at [k*2*WD +: 2*WD]
//   busy       : window partially filled
module pool_unit
  import pool_pkg::*;
#(
  parameter int WD       = 8,
  parameter int FI       = 3,
  parameter int CH       = 8,
  parameter int WIN_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [CH*WD-1:0]   in_data,
  input  logic               pool_mode,
  input  logic               flush,
  output logic               out_valid,
  output logic [CH*2*WD-1:0] out_data,
  output logic               busy
);

  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  pool_mode_e          mode_r_q, mode_r_d;
  pool_mode_e          mode_eff;
  logic                busy_q, out_valid_q;
  logic                beat, first, last;

  // A flush kills the beat it arrives with.
  assign beat  = in_valid && !flush;
  assign first = (cnt_q == '0);
  assign last  = (cnt_q == '1);

  always_comb begin
    // The first beat must see the live mode, not the stale latch.
    mode_eff = first ? pool_mode_e'(pool_mode) : mode_r_q;
    mode_r_d = (beat && first) ? pool_mode_e'(pool_mode) : mode_r_q;
    if (flush) begin
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mode_r_q    <= POOL_MAX;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mode_r_q    <= mode_r_d;
      busy_q      <= (cnt_d != '0);
      out_valid_q <= beat && last;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    pool_lane #(
      .WD       (WD),
      .FI       (FI),
      .WIN_LOG2 (WIN_LOG2)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .beat_i     (beat),
      .first_i    (first),
      .last_i     (last),
      .mode_i     (mode_eff),
      .x_i        (in_data[k*WD +: WD]),
      .out_data_o (out_data[k*2*WD +: 2*WD])
    );
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
